// File: rtl/prf_alloc_arbiter_pkg.sv
// rtl/prf_alloc_arbiter_pkg.sv - shared sizing constants for the PRF free-pool arbiter
package prf_alloc_arbiter_pkg;

  localparam int PR_SIZE        = 64;
  localparam int PR_BITS        = 6;
  localparam int ZERO_REG_PRN   = PR_SIZE - 1;
  localparam int NUM_THREADS    = 2;
  localparam int DISPATCH_WIDTH = 2;
  localparam int NUM_FREE_PORTS = 4;

  typedef logic [PR_BITS-1:0] prn_t;

  localparam prn_t ZERO_PRN = prn_t'(ZERO_REG_PRN);

endpackage

// File: rtl/prf_alloc_arbiter_if.sv
// rtl/prf_alloc_arbiter_if.sv - dispatch-side allocation request/grant bundle
interface prf_alloc_arbiter_if;
  import prf_alloc_arbiter_pkg::*;

  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0]              req;
  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0]              gnt;
  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0][PR_BITS-1:0] gnt_PRN;

  modport master (output req, input gnt, input gnt_PRN);
  modport slave  (input req, output gnt, output gnt_PRN);

endinterface

// File: rtl/prf_alloc_arbiter_pick2.sv
// rtl/prf_alloc_arbiter_pick2.sv - prf_pick2: combinational finder of the two lowest set bits
module prf_pick2
  import prf_alloc_arbiter_pkg::*;
(
  input  logic [PR_SIZE-1:0] bits,
  output prn_t               c0,
  output prn_t               c1,
  output logic               c0_valid,
  output logic               c1_valid
);

  always_comb begin
    c0       = ZERO_PRN;
    c1       = ZERO_PRN;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    for (int i = 0; i < PR_SIZE; i++) begin
      if (bits[i]) begin
        if (!c0_valid) begin
          c0       = prn_t'(i);
          c0_valid = 1'b1;
        end else if (!c1_valid) begin
          c1       = prn_t'(i);
          c1_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prf_alloc_arbiter.sv
// rtl/prf_alloc_arbiter.sv - two-thread physical register free pool with 2-per-cycle allocation
module prf_alloc_arbiter
  import prf_alloc_arbiter_pkg::*;
(
  input  logic                                        clock,
  input  logic                                        reset,
  prf_alloc_arbiter_if.slave                          bus,
  input  logic [NUM_FREE_PORTS-1:0][PR_BITS-1:0]      free_PRN_in,
  input  logic [NUM_THREADS-1:0]                      recover,
  input  logic [NUM_THREADS-1:0][PR_SIZE-1:0]         rrat_free_list,
  output logic [PR_BITS:0]                            free_count,
  output logic                                        prio_thread
);

  localparam logic [PR_SIZE-1:0] FREE_INIT = {1'b0, {(PR_SIZE-1){1'b1}}};

  logic [PR_SIZE-1:0]                      free_bm, free_nxt;
  logic [NUM_THREADS-1:0][PR_SIZE-1:0]     owner, owner_nxt;
  logic                                    prio, prio_nxt;

  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0]              eff_req;
  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0]              gnt_c;
  logic [NUM_THREADS-1:0][DISPATCH_WIDTH-1:0][PR_BITS-1:0] prn_c;

  prn_t c0, c1;
  logic c0_valid, c1_valid;

  prf_pick2 u_pick2 (
    .bits     (free_bm),
    .c0       (c0),
    .c1       (c1),
    .c0_valid (c0_valid),
    .c1_valid (c1_valid)
  );

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      eff_req[t] = bus.req[t] & {DISPATCH_WIDTH{~recover[t]}};
    end
  end

  // Serve prio slot0, prio slot1, other slot0, other slot1; first hit takes c0, second c1.
  always_comb begin
    int   used;
    logic th;
    int   s;
    gnt_c = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        prn_c[t][k] = ZERO_PRN;
      end
    end
    used = 0;
    th   = 1'b0;
    s    = 0;
    for (int k = 0; k < NUM_THREADS * DISPATCH_WIDTH; k++) begin
      th = (k < DISPATCH_WIDTH) ? prio : ~prio;
      s  = k % DISPATCH_WIDTH;
      if (eff_req[th][s]) begin
        if (used == 0 && c0_valid) begin
          gnt_c[th][s] = 1'b1;
          prn_c[th][s] = c0;
          used         = 1;
        end else if (used == 1 && c1_valid) begin
          gnt_c[th][s] = 1'b1;
          prn_c[th][s] = c1;
          used         = 2;
        end
      end
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.gnt_PRN = prn_c;

  // Grants are applied last so a stale release of a free PRN cannot undo a fresh allocation.
  always_comb begin
    free_nxt  = free_bm;
    owner_nxt = owner;
    for (int i = 0; i < NUM_FREE_PORTS; i++) begin
      if (free_PRN_in[i] != ZERO_PRN) begin
        free_nxt[free_PRN_in[i]] = 1'b1;
        for (int t = 0; t < NUM_THREADS; t++) begin
          owner_nxt[t][free_PRN_in[i]] = 1'b0;
        end
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (recover[t]) begin
        free_nxt     = free_nxt | (owner[t] & rrat_free_list[t]);
        owner_nxt[t] = owner_nxt[t] & ~(owner[t] & rrat_free_list[t]);
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (gnt_c[t][k]) begin
          free_nxt[prn_c[t][k]]     = 1'b0;
          owner_nxt[t][prn_c[t][k]] = 1'b1;
        end
      end
    end
    free_nxt[ZERO_REG_PRN] = 1'b0;
  end

  assign prio_nxt = prio ^ ((|eff_req[0]) & (|eff_req[1]));

  always_ff @(posedge clock) begin
    if (reset) begin
      free_bm <= FREE_INIT;
      owner   <= '0;
      prio    <= 1'b0;
    end else begin
      free_bm <= free_nxt;
      owner   <= owner_nxt;
      prio    <= prio_nxt;
    end
  end

  assign free_count  = (PR_BITS+1)'($countones(free_bm));
  assign prio_thread = prio;

endmodule

// File: tb/tb_prf_alloc_arbiter.sv
// tb/tb_prf_alloc_arbiter.sv - directed vector bench for prf_alloc_arbiter
module tb_prf_alloc_arbiter;
  import prf_alloc_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0][1:0]      req;
    logic [3:0][5:0]      fin;
    logic [1:0]           rec;
    logic [1:0][63:0]     rfl;
    logic [1:0][1:0]      egnt;
    logic [1:0][1:0][5:0] eprn;
    logic [6:0]           efc;
    logic                 eprio;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic [3:0][PR_BITS-1:0]  free_PRN_in;
  logic [1:0]               recover;
  logic [1:0][PR_SIZE-1:0]  rrat_free_list;
  logic [PR_BITS:0]         free_count;
  logic                     prio_thread;

  int total = 0;
  int bad   = 0;

  prf_alloc_arbiter_if bus ();

  prf_alloc_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .free_PRN_in    (free_PRN_in),
    .recover        (recover),
    .rrat_free_list (rrat_free_list),
    .free_count     (free_count),
    .prio_thread    (prio_thread)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input int fin0, input logic [1:0] rec,
                              input logic [63:0] rfl1, input int p00, input int p01,
                              input int p10, input int p11, input int fc, input logic pr);
    vec_t v;
    v.req      = r;
    v.fin      = {4{6'd63}};
    v.fin[0]   = 6'(fin0);
    v.rec      = rec;
    v.rfl[0]   = '1;
    v.rfl[1]   = rfl1;
    v.eprn[0][0] = 6'(p00);
    v.eprn[0][1] = 6'(p01);
    v.eprn[1][0] = 6'(p10);
    v.eprn[1][1] = 6'(p11);
    v.egnt[0][0] = (p00 != 63);
    v.egnt[0][1] = (p01 != 63);
    v.egnt[1][0] = (p10 != 63);
    v.egnt[1][1] = (p11 != 63);
    v.efc      = 7'(fc);
    v.eprio    = pr;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req        = '0;
    free_PRN_in    = {4{6'd63}};
    recover        = '0;
    rrat_free_list = '1;
  endtask

  vec_t vecs[7];
  logic [1:0][1:0][5:0] all_zero_prn;
  logic done;

  initial begin
    all_zero_prn = {4{6'd63}};
    vecs[0] = mk(4'b0000, 63, 2'b00, '1,          63, 63, 63, 63, 63, 1'b0);
    vecs[1] = mk(4'b1111, 63, 2'b00, '1,           0,  1, 63, 63, 63, 1'b0);
    vecs[2] = mk(4'b1111, 63, 2'b00, '1,          63, 63,  2,  3, 61, 1'b1);
    vecs[3] = mk(4'b0001,  0, 2'b00, '1,           4, 63, 63, 63, 59, 1'b0);
    vecs[4] = mk(4'b0001, 63, 2'b00, '1,           0, 63, 63, 63, 59, 1'b0);
    vecs[5] = mk(4'b1111, 63, 2'b10, ~64'h4,       5,  6, 63, 63, 58, 1'b0);
    vecs[6] = mk(4'b0100, 63, 2'b00, '1,          63, 63,  3, 63, 57, 1'b0);

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (i != 0) begin
        @(posedge clock);
        #1;
      end
      bus.req        = vecs[i].req;
      free_PRN_in    = vecs[i].fin;
      recover        = vecs[i].rec;
      rrat_free_list = vecs[i].rfl;
      @(negedge clock);
      chk($sformatf("v%0d gnt", i),        128'(bus.gnt),     128'(vecs[i].egnt));
      chk($sformatf("v%0d gnt_PRN", i),    128'(bus.gnt_PRN), 128'(vecs[i].eprn));
      chk($sformatf("v%0d free_count", i), 128'(free_count),  128'(vecs[i].efc));
      chk($sformatf("v%0d prio", i),       128'(prio_thread), 128'(vecs[i].eprio));
    end

    // Drain the pool with thread 0 until only PRN 62 remains.
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clock);
      #1;
      idle_inputs();
      if (free_count <= 1) done = 1'b1;
      else bus.req = (free_count >= 3) ? 4'b0011 : 4'b0001;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: pool never reached 1 free, free_count=%0d expected 1", free_count);
    end

    bus.req = 4'b1111;
    @(negedge clock);
    chk("exhaust gnt",        128'(bus.gnt),          128'(4'b0001));
    chk("exhaust prn00",      128'(bus.gnt_PRN[0][0]), 128'(6'd62));
    chk("exhaust prn10",      128'(bus.gnt_PRN[1][0]), 128'(6'd63));
    chk("exhaust free_count", 128'(free_count),       128'(7'd1));

    @(posedge clock);
    #1;
    @(negedge clock);
    chk("empty gnt",        128'(bus.gnt),     128'(4'b0000));
    chk("empty gnt_PRN",    128'(bus.gnt_PRN), 128'(all_zero_prn));
    chk("empty free_count", 128'(free_count),  128'(7'd0));
    chk("empty prio",       128'(prio_thread), 128'(1'b1));

    @(posedge clock);
    #1;
    reset          = 1'b1;
    bus.req        = 4'b1111;
    free_PRN_in[0] = 6'd7;
    free_PRN_in[1] = 6'd8;
    recover        = 2'b01;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    chk("post-reset free_count", 128'(free_count),  128'(7'd63));
    chk("post-reset prio",       128'(prio_thread), 128'(1'b0));
    chk("post-reset gnt",        128'(bus.gnt),     128'(4'b0000));
    chk("post-reset gnt_PRN",    128'(bus.gnt_PRN), 128'(all_zero_prn));

    @(posedge clock);
    #1;
    bus.req = 4'b0100;
    @(negedge clock);
    chk("post-reset alloc gnt", 128'(bus.gnt),          128'(4'b0100));
    chk("post-reset alloc prn", 128'(bus.gnt_PRN[1][0]), 128'(6'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prf_alloc_arbiter.md
Name: prf_alloc_arbiter

Overview:
- Owns the shared physical-register free pool for the two-thread, 2-wide core.
- Arbitrates up to 2 PRN allocations per cycle between the two threads' dispatch slots.
- Reclaims PRNs released by the RRAT at commit (4 per cycle).
- On a per-thread mispredict, bulk-reclaims every PRN owned by that thread that is not held in that thread's RRAT. Sits between dispatch/RAT and the rrat block.

Parameters:
- PR_SIZE, 64, number of physical registers. PRN PR_SIZE-1 is the reserved zero/invalid register and is never allocated.
- PR_BITS, 6, log2(PR_SIZE).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  [1:0][1:0]  request bit per [thread][slot]; slot 0 has priority over slot 1 within a thread.
- gnt  out  [1:0][1:0]  grant per [thread][slot]; combinational from registered state and inputs.
- gnt_PRN  out  [1:0][1:0][PR_BITS-1:0]  allocated PRN per [thread][slot]; PR_SIZE-1 when not granted.
- free_PRN_in  in  [3:0][PR_BITS-1:0]  PRNs released by the rrat; PR_SIZE-1 means none.
- recover  in  [1:0]  per-thread mispredict squash.
- rrat_free_list  in  [1:0][PR_SIZE-1:0]  per-thread RRAT free bitmap; 1 means the PRN is not mapped in that thread's RRAT.
- free_count  out  [PR_BITS:0]  number of free PRNs in registered state.
- prio_thread  out  1  thread currently holding arbitration priority.

Behaviour:
- State:
  - free_bm[PR_SIZE-1:0]; bit PR_SIZE-1 is forced to 0 at all times.
  - owner[1:0][PR_SIZE-1:0], marking PRNs allocated to each thread and not yet released.
  - prio, 1 bit.
- Reset:
  - free_bm = all ones except bit PR_SIZE-1.
  - owner = 0, prio = 0.
  - Resulting outputs: free_count = PR_SIZE-1, gnt = 0, every gnt_PRN = PR_SIZE-1.
  - Reset overrides every other input in the same cycle.
- Capacity: at most 2 grants per cycle in total.
  - Candidates are the lowest-index free PRN (c0) and the second-lowest (c1), both taken from registered free_bm.
  - If only one PRN is free, only c0 exists; if none is free, nothing is granted.
- Grant order: prio thread slot 0, prio thread slot 1, other thread slot 0, other thread slot 1.
  - Only asserted requests consume candidates, in that order.
  - The first served request receives c0; the second receives c1.
  - Partial grants are allowed; a thread never gets slot 1 granted while its slot 0 request is denied.
- Masking: req from thread t is ignored (gnt forced 0) in any cycle where recover[t]=1.
- Priority update: prio toggles at the clock edge iff both threads had at least one unmasked request that cycle; otherwise it holds.
- Allocation: granted PRNs clear their free_bm bit and set owner[t] at the next edge. No same-cycle reuse.
- Release: each free_PRN_in[i] != PR_SIZE-1 sets free_bm and clears owner[0] and owner[1] for that PRN at the next edge.
  - A freed PRN is not grantable in the cycle it arrives (no bypass).
  - Duplicate or already-free PRNs are harmless (idempotent).
- Recovery: at the edge, for thread t with recover[t]=1, every PRN p with owner[t][p] & rrat_free_list[t][p] is set free and its owner[t] bit cleared.
  - Both threads may recover in the same cycle.
  - Recovery, release and the other thread's grants all apply in the same edge; they touch disjoint or idempotent bits.
- free_count = popcount(free_bm).
- Latency: grant in the request cycle; state update after 1 cycle.

Decomposition:
- Shared package (sys_defs): PR_SIZE, PR_BITS, ZERO_REG_PRN = PR_SIZE-1, the thread count and dispatch width constants.
- One sub-module: prf_pick2, a combinational two-lowest-set-bit finder over PR_SIZE bits, returning c0, c1 and their valid flags.

Test Plan:
- Reset, then no requests:
  - free_count=63, all gnt=0, all gnt_PRN=63, prio_thread=0.
- Contention after reset: req thread0 {1,1}, thread1 {1,1}:
  - gnt[0]={1,1} with PRN 0,1; gnt[1]=0.
  - Next cycle with the same request: gnt[1]={1,1} with PRN 2,3; prio_thread=1 at that point.
  - Afterwards free_count=59.
- Release then reuse:
  - free_PRN_in={0,63,63,63}: no grant of PRN 0 that cycle.
  - Next cycle, req thread0 slot0 alone: gnt_PRN[0][0]=0.
- Exhaustion:
  - Drain the pool to 1 free PRN (PRN 62); req all four slots.
  - Only the prio thread's slot0 is granted, PRN 62; free_count goes to 0.
  - Following cycle: all gnt=0.
- Recovery:
  - Thread1 owns PRNs 2,3; rrat_free_list[1] has bit 2=0 and bit 3=1; recover[1]=1 with thread1 requesting.
  - Thread1 grants are 0; next cycle PRN 3 is free and PRN 2 is not; free_count rises by 1.
- Reset mid-operation:
  - With owners set, assert reset together with requests and free_PRN_in.
  - Next cycle the state equals post-reset: free_count=63, prio_thread=0.
